// File: rtl/newhope_pkg.sv
// Shared definitions for the NewHope RAM loader/reader blocks: the reader FSM
// state encoding and the address increment that wraps at the RAM depth.
package newhope_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_t;

  // Next word address; wraps at the last real word, not at the power of two
  function automatic logic [31:0] addr_inc(input logic [31:0] addr,
                                           input logic [31:0] mem_size);
    if (addr >= mem_size - 32'd1) begin
      return 32'd0;
    end
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/output_ram_reader_skid_fifo2.sv
// Two-entry FIFO whose head register drives the stream output directly.
// The head only changes when it is popped or loaded into an empty FIFO, so
// the presented word stays stable while the consumer stalls.
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             pop;

  assign pop        = (cnt != 2'd0) && ready;
  assign dout       = head;
  assign dout_valid = (cnt != 2'd0);
  assign count      = cnt;

  // Occupancy update; simultaneous push and pop are both honoured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            head <= din;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head <= din;
            2'b10: begin
              tail <= din;
              cnt  <= 2'd2;
            end
            2'b01: cnt <= 2'd0;
            default: ;
          endcase
        end
        default: begin
          if (pop) begin
            head <= tail;
            if (push) begin
              tail <= din;
            end else begin
              cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/output_ram_reader.sv
// Read-side controller for dual_port_ram port B. On start it streams LENGTH
// words from BASE_ADDR (wrapping at MEM_SIZE) out through a valid/ready
// interface, hiding the one-cycle RAM read latency with a two-entry FIFO.
module output_ram_reader
  import newhope_pkg::*;
#(
  parameter  int MEM_WIDTH = 8,
  parameter  int MEM_SIZE  = 896,
  localparam int ADDR_W    = $clog2(MEM_SIZE),
  localparam int LEN_W     = $clog2(MEM_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic                 enb,
  output logic                 web,
  output logic [ADDR_W-1:0]    addrb,
  input  logic [MEM_WIDTH-1:0] dob,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  rd_state_t        state;
  rd_state_t        state_next;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] sent;
  logic [ADDR_W-1:0] addr_r;
  logic             inflight;
  logic [1:0]       fifo_count;
  logic [1:0]       fifo_after_pop;
  logic [2:0]       pending;
  logic             fire;
  logic             credit_ok;

  assign web   = 1'b0;
  assign addrb = addr_r;
  assign fire  = dout_valid && dout_ready;

  // A word leaving the FIFO this cycle frees its slot for the read issued now,
  // which is what lets the stream run at one word per cycle.
  assign fifo_after_pop = fifo_count - {1'b0, fire};
  assign pending        = {1'b0, fifo_after_pop} + {2'b00, inflight};
  assign credit_ok      = (pending < 3'd2);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
        if (enb && (issued == len_r - LEN_W'(1))) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fire && (sent == len_r - LEN_W'(1))) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and the issue credit
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    enb  = 1'b0;
    case (state)
      ST_READ: begin
        busy = 1'b1;
        enb  = credit_ok;
      end
      ST_DRAIN: busy = 1'b1;
      ST_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Burst parameters, address and issue/sent counters; inflight marks a read
  // whose data appears on dob this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r    <= '0;
      issued   <= '0;
      sent     <= '0;
      addr_r   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= enb;
      if ((state == ST_IDLE) && start) begin
        len_r  <= length;
        addr_r <= base_addr;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (enb) begin
          addr_r <= ADDR_W'(addr_inc(32'(addr_r), 32'(MEM_SIZE)));
          issued <= issued + LEN_W'(1);
        end
        if (fire) begin
          sent <= sent + LEN_W'(1);
        end
      end
    end
  end

  skid_fifo2 #(
    .WIDTH (MEM_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .din        (dob),
    .ready      (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_output_ram_reader.sv
// Bench for output_ram_reader: a RAM model preloaded with ram[i] = i mod 256,
// a transaction-level reference of the expected stream, and directed bursts.
module tb_output_ram_reader;

  localparam int MW = 8;
  localparam int MS = 896;
  localparam int AW = $clog2(MS);
  localparam int LW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy, done, enb, web;
  logic [AW-1:0] addrb;
  logic [MW-1:0] dob = '0;
  logic [MW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  logic [MW-1:0] mem [0:MS-1];

  output_ram_reader #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .enb        (enb),
    .web        (web),
    .addrb      (addrb),
    .dob        (dob),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < MS; i++) mem[i] = MW'(i % 256);
  end

  // Port B of the RAM: one-cycle read latency
  always @(posedge clk) begin
    if (enb && !web) dob <= mem[addrb];
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  // Reference state
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] got_q[$];
  int            addr_q[$];
  int            fire_cyc_q[$];
  bit            m_active = 0;
  bit            done_due = 0;
  bit            done_next;
  int            issue_left = 0;
  int            m_addr = 0;
  int            outstanding = 0;
  int            cyc = 0;
  int            first_busy = -1, first_valid = -1, done_cyc = -1, accept_cyc = -1;
  int            done_count = 0;
  bit            prev_rst = 0, prev_valid = 0, prev_ready = 0;
  logic [MW-1:0] prev_dout = '0;
  bit            fire_i;

  // Per-cycle compare against the reference, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!prev_rst) begin
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_enb", enb, 0);
      chk("reset_valid", dout_valid, 0);
      chk("reset_addrb", addrb, 0);
      chk("reset_dout", dout, 0);
    end else begin
      fire_i = dout_valid && dout_ready;
      chk("done", done, done_due);
      chk("busy", busy, m_active);
      chk("web", web, 0);
      if (done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (enb) begin
        chk("enb_in_burst", issue_left > 0, 1);
        chk("addrb", addrb, m_addr);
        chk("buffer_credit", (outstanding - int'(fire_i)) < 2, 1);
        addr_q.push_back(int'(addrb));
        m_addr = (m_addr + 1) % MS;
        if (issue_left > 0) issue_left--;
        outstanding++;
      end
      if (dout_valid) chk("valid_expected", exp_q.size() > 0, 1);
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout, prev_dout);
      end
      done_next = 0;
      if (fire_i) begin
        got_q.push_back(dout);
        fire_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) begin
          chk("data", dout, exp_q[0]);
          void'(exp_q.pop_front());
        end
        outstanding--;
        if (m_active && exp_q.size() == 0) begin
          m_active  = 0;
          done_next = 1;
        end
      end
      if (busy && first_busy < 0) first_busy = cyc;
      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (start && !m_active && !done_due) begin
        accept_cyc = cyc;
        if (length == 0) begin
          done_next = 1;
        end else begin
          m_active   = 1;
          issue_left = int'(length);
          m_addr     = int'(base_addr);
          for (int k = 0; k < int'(length); k++)
            exp_q.push_back(mem[(int'(base_addr) + k) % MS]);
        end
      end
      done_due = done_next;
    end
    if (!rst_n) begin
      exp_q.delete();
      m_active = 0; done_due = 0; issue_left = 0; outstanding = 0;
    end
    prev_rst = rst_n; prev_valid = dout_valid; prev_ready = dout_ready; prev_dout = dout;
  end

  // Ready driver: held high, or the toggling pattern 1,0,0,1,0,1 when mode=1
  bit ready_mode = 0;
  initial begin
    logic pat [6];
    int   k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    k = 0;
    dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode) begin
        dout_ready = pat[k];
        k = (k + 1) % 6;
      end else begin
        dout_ready = 1'b1;
        k = 0;
      end
    end
  end

  task automatic clear_logs();
    got_q.delete(); addr_q.delete(); fire_cyc_q.delete();
    first_busy = -1; first_valid = -1; done_cyc = -1; accept_cyc = -1; done_count = 0;
  endtask

  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    base_addr = AW'(b); length = LW'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(posedge clk);
    while ((m_active || done_due) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("burst_timeout", n < 300, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_words(input string nm, input logic [MW-1:0] w [], input int n);
    chk({nm, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size()) chk(nm, got_q[i], w[i]);
  endtask

  initial begin
    logic [MW-1:0] w [];
    int            n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: base 0, length 4, ready high
    clear_logs();
    do_start(0, 4);
    wait_idle();
    w = '{8'h00, 8'h01, 8'h02, 8'h03};
    chk_words("t1_word", w, 4);
    chk("t1_first_valid_lat", first_valid - first_busy, 2);
    if (fire_cyc_q.size() == 4) chk("t1_back_to_back", fire_cyc_q[3] - fire_cyc_q[0], 3);
    if (fire_cyc_q.size() == 4) chk("t1_done_lat", done_cyc - fire_cyc_q[3], 1);

    // 2: wrap at MEM_SIZE
    clear_logs();
    do_start(894, 4);
    wait_idle();
    w = '{8'h7E, 8'h7F, 8'h00, 8'h01};
    chk_words("t2_word", w, 4);
    chk("t2_addr_count", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      chk("t2_addr0", addr_q[0], 894);
      chk("t2_addr1", addr_q[1], 895);
      chk("t2_addr2", addr_q[2], 0);
      chk("t2_addr3", addr_q[3], 1);
    end

    // 3: backpressure
    clear_logs();
    ready_mode = 1;
    do_start(10, 6);
    wait_idle();
    ready_mode = 0;
    w = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    chk_words("t3_word", w, 6);

    // 4: zero length
    clear_logs();
    do_start(5, 0);
    wait_idle();
    chk("t4_done_lat", done_cyc - accept_cyc, 1);
    chk("t4_no_reads", addr_q.size(), 0);
    chk("t4_no_words", got_q.size(), 0);
    chk("t4_done_pulses", done_count, 1);

    // 5: start while busy is ignored
    clear_logs();
    do_start(20, 8);
    repeat (2) @(posedge clk);
    do_start(100, 3);
    wait_idle();
    w = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    chk_words("t5_word", w, 8);
    chk("t5_done_pulses", done_count, 1);

    // 6: reset mid-burst, then a fresh burst
    clear_logs();
    do_start(40, 8);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t6_wait_timeout", n < 100, 1);
    #1 rst_n = 1'b0;
    done_count = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("t6_no_done", done_count, 0);
    clear_logs();
    do_start(0, 2);
    wait_idle();
    w = '{8'h00, 8'h01};
    chk_words("t6_word", w, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
